// File: rtl/clarvi_writeback.sv
// clarvi_writeback: write-back stage merging execute (buffered) and load results into one register-file write port
module clarvi_writeback #(
  parameter int XLEN          = 64,
  parameter int EX_FIFO_DEPTH = 2
) (
  input  logic                             clock,
  input  logic                             reset,
  input  logic                             ex_valid,
  output logic                             ex_ready,
  input  logic [4:0]                       ex_rd,
  input  logic [XLEN-1:0]                  ex_data,
  input  logic                             mem_valid,
  input  logic [4:0]                       mem_rd,
  input  logic [XLEN-1:0]                  mem_data,
  input  logic [2:0]                       mem_funct3,
  input  logic [2:0]                       mem_offset,
  output logic [4:0]                       write_register,
  output logic [XLEN-1:0]                  data_in,
  output logic                             write_enable,
  output logic                             mem_error,
  output logic [$clog2(EX_FIFO_DEPTH):0]   fifo_count
);
  localparam int AW = $clog2(EX_FIFO_DEPTH);
  localparam int CW = AW + 1;
  typedef struct packed {
    logic [4:0]      rd;
    logic [XLEN-1:0] data;
  } entry_t;
  entry_t          fifo_q [EX_FIFO_DEPTH];
  entry_t          fifo_d [EX_FIFO_DEPTH];
  entry_t          head;
  logic [AW-1:0]   head_q, head_d, tail_q, tail_d;
  logic [CW-1:0]   count_q, count_d;
  logic [4:0]      write_register_q, write_register_d;
  logic [XLEN-1:0] data_in_q, data_in_d;
  logic            write_enable_q, write_enable_d;
  logic            mem_error_q, mem_error_d;
  logic            ex_fire, push, pop, reserved;
  logic [7:0]      b_lane;
  logic [15:0]     h_lane;
  logic [31:0]     w_lane;
  logic [XLEN-1:0] load_val;
  // ex_ready depends only on registered occupancy, never on mem_valid
  assign ex_ready = !reset && (count_q < CW'(EX_FIFO_DEPTH));
  assign ex_fire  = ex_valid && ex_ready;
  assign reserved = mem_funct3 == 3'b111;
  assign head     = fifo_q[head_q];
  // Lanes are always naturally aligned: low offset bits below the access size drop out of the shift
  assign b_lane = 8'(mem_data >> {mem_offset, 3'b000});
  assign h_lane = 16'(mem_data >> {mem_offset[2:1], 4'b0000});
  assign w_lane = 32'(mem_data >> {mem_offset[2], 5'b00000});
  // Load result extension by funct3; reserved encoding yields zero and is never written
  always_comb begin
    load_val = '0;
    case (mem_funct3)
      3'b000:  load_val = {{(XLEN-8){b_lane[7]}}, b_lane};
      3'b001:  load_val = {{(XLEN-16){h_lane[15]}}, h_lane};
      3'b010:  load_val = {{(XLEN-32){w_lane[31]}}, w_lane};
      3'b011:  load_val = mem_data;
      3'b100:  load_val = {{(XLEN-8){1'b0}}, b_lane};
      3'b101:  load_val = {{(XLEN-16){1'b0}}, h_lane};
      3'b110:  load_val = {{(XLEN-32){1'b0}}, w_lane};
      default: load_val = '0;
    endcase
  end
  // Write-slot arbitration: load first, then FIFO head, then execute bypass; FIFO push/pop bookkeeping
  always_comb begin
    fifo_d           = fifo_q;
    head_d           = head_q;
    tail_d           = tail_q;
    write_register_d = write_register_q;
    data_in_d        = data_in_q;
    write_enable_d   = 1'b0;
    mem_error_d      = 1'b0;
    push             = 1'b0;
    pop              = 1'b0;
    if (mem_valid) begin
      write_register_d = reserved ? write_register_q : mem_rd;
      data_in_d        = reserved ? data_in_q : load_val;
      write_enable_d   = !reserved && (mem_rd != 5'd0);
      mem_error_d      = reserved;
      push             = ex_fire;
    end else if (count_q != '0) begin
      write_register_d = head.rd;
      data_in_d        = head.data;
      write_enable_d   = head.rd != 5'd0;
      pop              = 1'b1;
      push             = ex_fire;
    end else if (ex_fire) begin
      write_register_d = ex_rd;
      data_in_d        = ex_data;
      write_enable_d   = ex_rd != 5'd0;
    end
    if (push) begin
      fifo_d[tail_q] = '{rd: ex_rd, data: ex_data};
      tail_d         = tail_q + 1'b1;
    end
    head_d  = pop ? head_q + 1'b1 : head_q;
    count_d = count_q + CW'(push) - CW'(pop);
  end
  // State and registered outputs; reset discards queued entries and clears the write port
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < EX_FIFO_DEPTH; i++) fifo_q[i] <= '0;
      head_q           <= '0;
      tail_q           <= '0;
      count_q          <= '0;
      write_register_q <= '0;
      data_in_q        <= '0;
      write_enable_q   <= 1'b0;
      mem_error_q      <= 1'b0;
    end else begin
      fifo_q           <= fifo_d;
      head_q           <= head_d;
      tail_q           <= tail_d;
      count_q          <= count_d;
      write_register_q <= write_register_d;
      data_in_q        <= data_in_d;
      write_enable_q   <= write_enable_d;
      mem_error_q      <= mem_error_d;
    end
  end
  assign write_register = write_register_q;
  assign data_in        = data_in_q;
  assign write_enable   = write_enable_q;
  assign mem_error      = mem_error_q;
  assign fifo_count     = count_q;
endmodule
